axis_rr_packet_arbiter: RTL and testbench
=========================================

Name: axis_rr_packet_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one AXI-stream sink (typically an axis_fifo_xpm instance) between N_INPUTS producers.
- Grants one input at a time and holds the grant until that input's tlast beat is accepted, so packets are never interleaved.
- Output is a single registered stage with full valid/ready backpressure, placed directly in front of the shared FIFO's slave port.

Parameters:
- N_INPUTS, 4: number of requesting slave streams (2..16).
- DATA_WIDTH, 32: tdata width on all ports.
- DEST_WIDTH, 16: tdest width on all ports.
- USER_WIDTH, 32: tuser width on all ports.

Ports:
- clock, input, 1: sole clock domain.
- reset, input, 1: asynchronous, active-low reset.
- in[N_INPUTS], axi_stream.slave, DATA/DEST/USER widths: requester streams (data, dest, user, tlast, valid, ready).
- out, axi_stream.master, DATA/DEST/USER widths: arbitrated stream to the shared FIFO.
- grant_idx, output, $clog2(N_INPUTS): index of the currently or last granted input.
- busy, output, 1: high while in LOCKED.

Behaviour:
- Reset, asynchronous, asserted low:
  - out.valid=0; out.data/dest/user/tlast=0.
  - All in[i].ready=0.
  - state=IDLE; grant_idx=0; busy=0.
  - last_grant=N_INPUTS-1, so input 0 wins first.
- Reset mid-packet: the packet is abandoned and the output register is cleared. There is no recovery or flush; upstream must also be reset.
- States: IDLE, LOCKED.
- IDLE:
  - If any in[i].valid, select the first valid index scanning last_grant+1, last_grant+2, ... modulo N_INPUTS.
  - Register it into grant_idx; next state is LOCKED.
  - No beat is accepted in IDLE. Arbitration costs 1 cycle per packet.
  - No valid inputs: remain in IDLE.
- LOCKED:
  - in[grant_idx].ready = !out.valid || out.ready. All other ready signals are 0.
  - Accepted beat (valid && ready) is captured into the output register: out.valid=1 on the next cycle. Latency is 1 cycle.
  - The output register holds while out.valid && !out.ready (AXI rule: stable payload).
  - If out.ready and no new beat is accepted, out.valid clears.
  - Accepted beat with tlast=1: last_grant <= grant_idx; next state is IDLE.
  - Granted input deasserting valid mid-packet: stay LOCKED indefinitely. There is no timeout.
- Throughput: 1 beat/cycle within a packet under continuous out.ready; 1 bubble cycle between packets.
- Simultaneous tlast acceptance and new requests: the new grant is decided in the following IDLE cycle, using the updated last_grant.
- Single-beat packets (tlast on first beat) are legal: LOCKED lasts 1 cycle.
- ready must not depend combinationally on in[i].valid. This avoids loops with the FIFO.

Optional Feature:
- Macro: AXIS_ARB_SOURCE_TAG_EN.
- Defined: out.dest is overwritten with grant_idx (zero-extended to DEST_WIDTH) on every captured beat, so downstream can demultiplex by source.
- Undefined: in[grant_idx].dest passes through unchanged.

Decomposition:
- Package axis_arbiter_pkg:
  - enum arb_state_t {IDLE, LOCKED}.
  - Function idx_width(n) returning max(1, $clog2(n)).
- Sub-module rr_priority_select:
  - Combinational rotate-and-priority-encode.
  - Inputs: request vector, last_grant. Outputs: next index, any_req.
  - Reused elsewhere for register-bus arbitration.

Test Plan:
- After reset release, inputs 0 and 2 both present a 3-beat packet (data 0x10..0x12 and 0x20..0x22), out.ready=1 -> out shows 0x10,0x11,0x12, 1 idle cycle, then 0x20,0x21,0x22; tlast set on 0x12 and 0x22; grant_idx 0 then 2.
- All 4 inputs continuously send 1-beat packets -> grant order 0,1,2,3,0,...; one beat every 2 cycles; no input starved.
- Input 1 mid-packet, out.ready held low for 5 cycles -> out.data/tlast stable, in[1].ready=0 for those cycles, no beat lost or duplicated; a scoreboard matches all 4 beats.
- Input 1 drops valid for 3 cycles mid-packet while input 3 is valid -> grant stays 1, in[3].ready=0 until input 1's tlast is accepted.
- reset asserted low mid-packet (after 2 of 4 beats) -> out.valid=0 and all ready=0 in the same cycle (async); after release, input 0 is granted first.
- With AXIS_ARB_SOURCE_TAG_EN defined, input 2 sends dest=0xABCD -> out.dest=0x0002; without the macro -> out.dest=0xABCD.

Source files
------------

// File: rtl/axis_arbiter_pkg.sv
// Shared types and helpers for the AXI-stream packet arbiter.
// Imported by axis_rr_packet_arbiter and rr_priority_select.
package axis_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE,
        LOCKED
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating priority encoder: first set request after last_grant, mod N.
// Purely combinational; also used for register-bus arbitration.
module rr_priority_select
    import axis_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] next_idx,
    output logic          any_req
);

    logic [IW:0] pos;

    // Scan farthest offset first so the nearest requester wins last.
    always_comb begin
        next_idx = '0;
        any_req  = 1'b0;
        pos      = '0;
        for (int i = N; i >= 1; i--) begin
            pos = {1'b0, last_grant} + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (req[pos[IW-1:0]]) begin
                next_idx = pos[IW-1:0];
                any_req  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-locked round-robin AXI-stream arbiter with a registered output.
// Define AXIS_ARB_SOURCE_TAG_EN to replace out_dest with the source index.
module axis_rr_packet_arbiter
    import axis_arbiter_pkg::*;
#(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 16,
    parameter int USER_WIDTH = 32,
    localparam int IW        = idx_width(N_INPUTS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [N_INPUTS*DEST_WIDTH-1:0] in_dest,
    input  logic [N_INPUTS*USER_WIDTH-1:0] in_user,
    input  logic [N_INPUTS-1:0]            in_tlast,
    input  logic [N_INPUTS-1:0]            in_valid,
    output logic [N_INPUTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [DEST_WIDTH-1:0]          out_dest,
    output logic [USER_WIDTH-1:0]          out_user,
    output logic                           out_tlast,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IW-1:0]                  grant_idx,
    output logic                           busy
);

    arb_state_t state, state_nxt;

    logic [IW-1:0]         last_grant;
    logic [IW-1:0]         sel_idx;
    logic                  any_req;
    logic                  can_take;
    logic                  accept;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [DEST_WIDTH-1:0] cur_dest;
    logic [USER_WIDTH-1:0] cur_user;
    logic                  cur_last;

    rr_priority_select #(
        .N  (N_INPUTS),
        .IW (IW)
    ) u_sel (
        .req        (in_valid),
        .last_grant (last_grant),
        .next_idx   (sel_idx),
        .any_req    (any_req)
    );

    assign cur_data = in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign cur_user = in_user[int'(grant_idx)*USER_WIDTH +: USER_WIDTH];
    assign cur_last = in_tlast[grant_idx];

`ifdef AXIS_ARB_SOURCE_TAG_EN
    assign cur_dest = DEST_WIDTH'(grant_idx);
`else
    assign cur_dest = in_dest[int'(grant_idx)*DEST_WIDTH +: DEST_WIDTH];
`endif

    // Ready depends only on state and the output register, never on valid.
    assign can_take = (state == LOCKED) && (!out_valid || out_ready);
    assign accept   = can_take && in_valid[grant_idx];
    assign busy     = (state == LOCKED);

    always_comb begin
        in_ready = '0;
        if (can_take) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && cur_last) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_idx  <= '0;
            last_grant <= IW'(N_INPUTS - 1);
        end else begin
            if (state == IDLE && any_req) begin
                grant_idx <= sel_idx;
            end
            if (accept && cur_last) begin
                last_grant <= grant_idx;
            end
        end
    end

    // Output stage drains in either state; it only loads while LOCKED.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dest  <= '0;
            out_user  <= '0;
            out_tlast <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= cur_data;
            out_dest  <= cur_dest;
            out_user  <= cur_user;
            out_tlast <= cur_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed self-checking bench for axis_rr_packet_arbiter (4 inputs).
// Honours AXIS_ARB_SOURCE_TAG_EN for the expected out_dest value.
module tb_axis_rr_packet_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int DSW = 16;
    localparam int UW  = 32;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N*DW-1:0]  in_data;
    logic [N*DSW-1:0] in_dest;
    logic [N*UW-1:0]  in_user;
    logic [N-1:0]     in_tlast;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [DW-1:0]    out_data;
    logic [DSW-1:0]   out_dest;
    logic [UW-1:0]    out_user;
    logic             out_tlast;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       grant_idx;
    logic             busy;

    always #5 clock = ~clock;

    axis_rr_packet_arbiter #(
        .N_INPUTS   (N),
        .DATA_WIDTH (DW),
        .DEST_WIDTH (DSW),
        .USER_WIDTH (UW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_user   (in_user),
        .in_tlast  (in_tlast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_dest  (out_dest),
        .out_user  (out_user),
        .out_tlast (out_tlast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] dest;
        logic [31:0] user;
        logic        last;
    } beat_t;

    beat_t src_mem [N][8];
    int    src_cnt [N];
    int    src_ptr [N];
    logic  en      [N];
    logic  ordy;
    int    stepn;
    beat_t outq[$];
    int    outstep[$];
    int    checks = 0;
    int    errors = 0;

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_cnt[i] = 0;
            src_ptr[i] = 0;
            en[i]      = 1'b1;
        end
        outq.delete();
        outstep.delete();
        stepn = 0;
    endtask

    task automatic push(input int i, input logic [31:0] d,
                        input logic [15:0] de, input logic [31:0] u,
                        input logic l);
        beat_t b;
        b.data = d;
        b.dest = de;
        b.user = u;
        b.last = l;
        src_mem[i][src_cnt[i]] = b;
        src_cnt[i]++;
    endtask

    task automatic drive_idle();
        in_valid = '0;
        in_data  = '0;
        in_dest  = '0;
        in_user  = '0;
        in_tlast = '0;
    endtask

    // One cycle: drive at negedge, sample handshakes that the next posedge takes.
    task automatic step();
        beat_t b;
        @(negedge clock);
        stepn++;
        for (int i = 0; i < N; i++) begin
            if (en[i] && src_ptr[i] < src_cnt[i]) begin
                b = src_mem[i][src_ptr[i]];
                in_valid[i]           = 1'b1;
                in_data[i*DW +: DW]   = b.data;
                in_dest[i*DSW +: DSW] = b.dest;
                in_user[i*UW +: UW]   = b.user;
                in_tlast[i]           = b.last;
            end else begin
                in_valid[i]           = 1'b0;
                in_data[i*DW +: DW]   = '0;
                in_dest[i*DSW +: DSW] = '0;
                in_user[i*UW +: UW]   = '0;
                in_tlast[i]           = 1'b0;
            end
        end
        out_ready = ordy;
        #1;
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && in_ready[i]) src_ptr[i]++;
        end
        if (out_valid && out_ready) begin
            b.data = out_data;
            b.dest = out_dest;
            b.user = out_user;
            b.last = out_tlast;
            outq.push_back(b);
            outstep.push_back(stepn);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_src();
        drive_idle();
        ordy      = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_src();
        drive_idle();
        ordy      = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_in_ready: got %b expected 0000", in_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy: got %b expected 0", busy);
        end
        checks++;
        if (grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL rst_grant: got %0d expected 0", grant_idx);
        end
        checks++;
        if (out_data !== 32'h0 || out_tlast !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_payload: got %h/%b expected 0/0",
                     out_data, out_tlast);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got busy=%b valid=%b expected 0/0",
                     busy, out_valid);
        end
    endtask

    task automatic test_two_packets();
        logic [9:0]  vbits;
        logic [1:0]  g_first;
        logic [1:0]  g_second;
        logic [31:0] exp_d [6];
        logic        exp_l [6];
        exp_d = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h21, 32'h22};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        push(0, 32'h10, 16'h0, 32'h0, 1'b0);
        push(0, 32'h11, 16'h0, 32'h0, 1'b0);
        push(0, 32'h12, 16'h0, 32'h0, 1'b1);
        push(2, 32'h20, 16'h0, 32'h0, 1'b0);
        push(2, 32'h21, 16'h0, 32'h0, 1'b0);
        push(2, 32'h22, 16'h0, 32'h0, 1'b1);
        vbits    = '0;
        g_first  = '1;
        g_second = '1;
        for (int s = 0; s < 10; s++) begin
            step();
            vbits[s] = out_valid;
            if (s == 2) g_first = grant_idx;
            if (s == 6) g_second = grant_idx;
        end
        checks++;
        if (vbits !== 10'h1DC) begin
            errors++;
            $display("FAIL pkt_valid_trace: got %b expected %b",
                     vbits, 10'h1DC);
        end
        checks++;
        if (g_first !== 2'd0 || g_second !== 2'd2) begin
            errors++;
            $display("FAIL pkt_grants: got %0d,%0d expected 0,2",
                     g_first, g_second);
        end
        checks++;
        if (outq.size() !== 6) begin
            errors++;
            $display("FAIL pkt_count: got %0d expected 6", outq.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (outq[k].data !== exp_d[k] || outq[k].last !== exp_l[k]) begin
                    errors++;
                    $display("FAIL pkt_beat%0d: got %h/%b expected %h/%b", k,
                             outq[k].data, outq[k].last, exp_d[k], exp_l[k]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_d [8];
        exp_d = '{32'h40, 32'h41, 32'h42, 32'h43,
                  32'h48, 32'h49, 32'h4A, 32'h4B};
        do_reset();
        for (int i = 0; i < N; i++) begin
            push(i, 32'h40 + 32'(i), 16'h0, 32'h0, 1'b1);
            push(i, 32'h48 + 32'(i), 16'h0, 32'h0, 1'b1);
        end
        repeat (20) step();
        checks++;
        if (outq.size() !== 8) begin
            errors++;
            $display("FAIL rr_count: got %0d expected 8", outq.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (outq[k].data !== exp_d[k]) begin
                    errors++;
                    $display("FAIL rr_order%0d: got %h expected %h", k,
                             outq[k].data, exp_d[k]);
                end
            end
            checks++;
            if (outstep[0] !== 3) begin
                errors++;
                $display("FAIL rr_first_step: got %0d expected 3", outstep[0]);
            end
            for (int k = 1; k < 8; k++) begin
                checks++;
                if (outstep[k] - outstep[k-1] !== 2) begin
                    errors++;
                    $display("FAIL rr_spacing%0d: got %0d expected 2", k,
                             outstep[k] - outstep[k-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [4];
        logic        exp_l [4];
        exp_d = '{32'h30, 32'h31, 32'h32, 32'h33};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        push(1, 32'h30, 16'h0, 32'h0, 1'b0);
        push(1, 32'h31, 16'h0, 32'h0, 1'b0);
        push(1, 32'h32, 16'h0, 32'h0, 1'b0);
        push(1, 32'h33, 16'h0, 32'h0, 1'b1);
        repeat (3) step();
        ordy = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h31 ||
                out_tlast !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got %b/%h/%b expected 1/31/0", s,
                         out_valid, out_data, out_tlast);
            end
            checks++;
            if (in_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready%0d: got %b expected 0", s, in_ready[1]);
            end
        end
        ordy = 1'b1;
        repeat (6) step();
        checks++;
        if (outq.size() !== 4 || src_ptr[1] !== 4) begin
            errors++;
            $display("FAIL bp_count: got out=%0d taken=%0d expected 4/4",
                     outq.size(), src_ptr[1]);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (outq[k].data !== exp_d[k] || outq[k].last !== exp_l[k]) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", k,
                             outq[k].data, outq[k].last, exp_d[k], exp_l[k]);
                end
            end
        end
    endtask

    task automatic test_valid_drop();
        logic        r3_seen;
        logic [31:0] exp_d [5];
        exp_d = '{32'h50, 32'h51, 32'h52, 32'h53, 32'h70};
        do_reset();
        push(1, 32'h50, 16'h0, 32'h0, 1'b0);
        push(1, 32'h51, 16'h0, 32'h0, 1'b0);
        push(1, 32'h52, 16'h0, 32'h0, 1'b0);
        push(1, 32'h53, 16'h0, 32'h0, 1'b1);
        push(3, 32'h70, 16'h0, 32'h0, 1'b1);
        r3_seen = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            r3_seen |= in_ready[3];
        end
        en[1] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            r3_seen |= in_ready[3];
            checks++;
            if (grant_idx !== 2'd1 || busy !== 1'b1 || in_ready[1] !== 1'b1) begin
                errors++;
                $display("FAIL drop_hold%0d: got g=%0d busy=%b rdy1=%b expected 1/1/1",
                         s, grant_idx, busy, in_ready[1]);
            end
        end
        en[1] = 1'b1;
        for (int s = 0; s < 2; s++) begin
            step();
            r3_seen |= in_ready[3];
        end
        checks++;
        if (r3_seen !== 1'b0) begin
            errors++;
            $display("FAIL drop_rdy3: got %b expected 0", r3_seen);
        end
        repeat (6) step();
        checks++;
        if (grant_idx !== 2'd3) begin
            errors++;
            $display("FAIL drop_next_grant: got %0d expected 3", grant_idx);
        end
        checks++;
        if (outq.size() !== 5) begin
            errors++;
            $display("FAIL drop_count: got %0d expected 5", outq.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (outq[k].data !== exp_d[k]) begin
                    errors++;
                    $display("FAIL drop_beat%0d: got %h expected %h", k,
                             outq[k].data, exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        push(2, 32'h60, 16'h0, 32'h0, 1'b0);
        push(2, 32'h61, 16'h0, 32'h0, 1'b0);
        push(2, 32'h62, 16'h0, 32'h0, 1'b0);
        push(2, 32'h63, 16'h0, 32'h0, 1'b1);
        repeat (3) step();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL mid_pre: got busy=%b valid=%b rdy=%b expected 1/1/0100",
                     busy, out_valid, in_ready);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: got valid=%b rdy=%b busy=%b expected 0/0000/0",
                     out_valid, in_ready, busy);
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_data_clr: got %h expected 0", out_data);
        end
        clear_src();
        drive_idle();
        @(negedge clock);
        reset = 1'b1;
        push(0, 32'h80, 16'h0, 32'h0, 1'b1);
        push(2, 32'h90, 16'h0, 32'h0, 1'b1);
        repeat (2) step();
        checks++;
        if (grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL mid_regrant: got %0d expected 0", grant_idx);
        end
        repeat (4) step();
        checks++;
        if (outq.size() !== 2) begin
            errors++;
            $display("FAIL mid_count: got %0d expected 2", outq.size());
        end else begin
            checks++;
            if (outq[0].data !== 32'h80 || outq[1].data !== 32'h90) begin
                errors++;
                $display("FAIL mid_order: got %h,%h expected 80,90",
                         outq[0].data, outq[1].data);
            end
        end
    endtask

    task automatic test_dest();
        logic [15:0] exp_dest;
`ifdef AXIS_ARB_SOURCE_TAG_EN
        exp_dest = 16'h0002;
`else
        exp_dest = 16'hABCD;
`endif
        do_reset();
        push(2, 32'hD0, 16'hABCD, 32'h1234_5678, 1'b1);
        repeat (4) step();
        checks++;
        if (outq.size() !== 1) begin
            errors++;
            $display("FAIL dest_count: got %0d expected 1", outq.size());
        end else begin
            checks++;
            if (outq[0].dest !== exp_dest) begin
                errors++;
                $display("FAIL dest_value: got %h expected %h",
                         outq[0].dest, exp_dest);
            end
            checks++;
            if (outq[0].user !== 32'h1234_5678 || outq[0].data !== 32'hD0) begin
                errors++;
                $display("FAIL dest_payload: got %h/%h expected 12345678/d0",
                         outq[0].user, outq[0].data);
            end
        end
    endtask

    initial begin
        drive_idle();
        out_ready = 1'b1;
        ordy      = 1'b1;
        #3;
        test_reset();
        test_two_packets();
        test_round_robin();
        test_backpressure();
        test_valid_drop();
        test_reset_mid_packet();
        test_dest();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
